// File: rtl/hdmi_packet_pkg.sv
// hdmi_packet_pkg
//   Shared definitions for the HDMI sink-side packet demultiplexer:
//   data-island packet type codes, the subpacket container type, the
//   audio FSM state encoding and the InfoFrame checksum helper.
package hdmi_packet_pkg;

  localparam logic [7:0] PKT_NULL         = 8'h00;
  localparam logic [7:0] PKT_ACR          = 8'h01;
  localparam logic [7:0] PKT_AUDIO_SAMPLE = 8'h02;
  localparam logic [7:0] PKT_AVI_IF       = 8'h82;
  localparam logic [7:0] PKT_AUDIO_IF     = 8'h84;

  // Subpacket k, byte SBn = sub[k][8n+7:8n]
  typedef logic [55:0] subpacket_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_UNPACK = 1'b1
  } demux_state_e;

  // 8-bit sum of HB0..HB2 and all 28 subpacket bytes; a valid packet sums to 0.
  function automatic logic [7:0] packet_checksum(input logic [23:0]      header,
                                                 input subpacket_t [3:0] sub);
    logic [7:0] sum;
    sum = header[7:0] + header[15:8] + header[23:16];
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < 7; b++) begin
        sum = sum + sub[k][8*b +: 8];
      end
    end
    return sum;
  endfunction

endpackage

// File: rtl/packet_demux_if.sv
// packet_demux_if
//   Bundles the packet input bus (packet_valid/ecc_ok/header/sub) and the
//   audio sample stream (audio_valid/audio_ready/audio_sample_word/
//   audio_frame_start).
//   master : packet source and audio consumer (drives packets and ready)
//   slave  : the demultiplexer (receives packets, drives the audio stream)
interface packet_demux_if
  import hdmi_packet_pkg::*;
#(
  parameter int AUDIO_BIT_WIDTH = 16
);
  logic                              packet_valid;
  logic                              ecc_ok;
  logic [23:0]                       header;
  subpacket_t [3:0]                  sub;
  logic                              audio_valid;
  logic                              audio_ready;
  logic [1:0][AUDIO_BIT_WIDTH-1:0]   audio_sample_word;
  logic                              audio_frame_start;

  modport master (
    output packet_valid, ecc_ok, header, sub, audio_ready,
    input  audio_valid, audio_sample_word, audio_frame_start
  );

  modport slave (
    input  packet_valid, ecc_ok, header, sub, audio_ready,
    output audio_valid, audio_sample_word, audio_frame_start
  );
endinterface

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo
//   Single-clock first-word-fall-through FIFO for stereo audio samples.
//   Ports: clk_pixel, reset_n (async active-low), push_i/data_i write side,
//   pop_i/head_o read side, full_o/empty_o status. A push while full is
//   accepted only when a pop happens in the same cycle.
module audio_sample_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic             clk_pixel,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Head forced to 0 when empty so the output is defined out of reset.
  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/packet_demux.sv
// packet_demux
//   Sink-side data-island packet dispatcher. One assembled packet per
//   packet_valid strobe is decoded by HB0: audio samples go to a FWFT FIFO,
//   ACR yields cts/n, AVI and Audio InfoFrames update captured fields after
//   a checksum test, and ECC failures are counted.
//   Ports: clk_pixel, reset_n, bus (packet_demux_if.slave), acr_update, cts,
//   n, video_id_code, audio_channel_count, audio_sample_freq,
//   infoframe_error, ecc_error_count, overflow, and parity_error when
//   AUDIO_PARITY_CHECK_EN is defined (per-channel P bit check; failing
//   channels are pushed as zero).
//
//   state     | meaning
//   ST_IDLE   | waiting for a packet; all packet types decoded here
//   ST_UNPACK | pushing one present subpacket per cycle, lowest k first
module packet_demux
  import hdmi_packet_pkg::*;
#(
  parameter int AUDIO_BIT_WIDTH = 16,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                 clk_pixel,
  input  logic                 reset_n,
  packet_demux_if.slave        bus,
  output logic                 acr_update,
  output logic [19:0]          cts,
  output logic [19:0]          n,
  output logic [6:0]           video_id_code,
  output logic [2:0]           audio_channel_count,
  output logic [2:0]           audio_sample_freq,
  output logic                 infoframe_error,
  output logic [15:0]          ecc_error_count,
`ifdef AUDIO_PARITY_CHECK_EN
  output logic                 parity_error,
`endif
  output logic                 overflow
);
  localparam int W = AUDIO_BIT_WIDTH;

  demux_state_e     state_q, state_d;
  subpacket_t [3:0] sub_q, sub_d;
  logic [3:0]       mask_q, mask_d;
  logic [3:0]       bflag_q, bflag_d;

  logic             acr_update_q, if_err_q, overflow_q;
  logic [19:0]      cts_q, n_q;
  logic [6:0]       vic_q;
  logic [2:0]       ch_q, freq_q;
  logic [15:0]      ecc_cnt_q;

  logic [7:0]       hb0, hb1, hb2;
  logic             accept, accept_idle, checksum_ok;
  logic [1:0]       cur_k;
  subpacket_t       cur_sub;
  logic [23:0]      left24, right24;
  logic [W-1:0]     left_s, right_s;
  logic             push, pop, fifo_full, fifo_empty;
  logic [2*W:0]     fifo_head;
  logic             unused_cur_bits;

  assign hb0         = bus.header[7:0];
  assign hb1         = bus.header[15:8];
  assign hb2         = bus.header[23:16];
  assign accept      = bus.packet_valid && bus.ecc_ok;
  assign accept_idle = accept && (state_q == ST_IDLE);
  assign checksum_ok = (packet_checksum(bus.header, bus.sub) == 8'h00);

  // Lowest present subpacket is the one pushed this cycle.
  always_comb begin
    cur_k = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (mask_q[k]) cur_k = k[1:0];
    end
  end

  assign cur_sub = sub_q[cur_k];
  assign left24  = cur_sub[23:0];
  assign right24 = cur_sub[47:24];
  assign unused_cur_bits = ^cur_sub;

`ifdef AUDIO_PARITY_CHECK_EN
  logic par_ok_l, par_ok_r;
  // SB6 = {P_R, C_R, U_R, V_R, P_L, C_L, U_L, V_L}
  assign par_ok_l     = (cur_sub[51] == ^{left24,  cur_sub[50:48]});
  assign par_ok_r     = (cur_sub[55] == ^{right24, cur_sub[54:52]});
  assign left_s       = par_ok_l ? left24[23 -: W]  : '0;
  assign right_s      = par_ok_r ? right24[23 -: W] : '0;
  assign parity_error = push && !(par_ok_l && par_ok_r);
`else
  assign left_s  = left24[23 -: W];
  assign right_s = right24[23 -: W];
`endif

  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    mask_d  = mask_q;
    bflag_d = bflag_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && hb0 == PKT_AUDIO_SAMPLE && !hb1[4] && hb1[3:0] != 4'd0) begin
          state_d = ST_UNPACK;
          sub_d   = bus.sub;
          mask_d  = hb1[3:0];
          bflag_d = hb2[3:0];
        end
      end
      ST_UNPACK: begin
        push   = 1'b1;
        mask_d = mask_q & (mask_q - 4'd1);
        if (mask_d == 4'd0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pop = !fifo_empty && bus.audio_ready;

  audio_sample_fifo #(
    .WIDTH (2*W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .push_i    (push),
    .data_i    ({bflag_q[cur_k], right_s, left_s}),
    .pop_i     (pop),
    .head_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign bus.audio_valid       = !fifo_empty;
  assign bus.audio_frame_start = fifo_head[2*W];
  assign bus.audio_sample_word = fifo_head[2*W-1:0];

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      sub_q        <= '0;
      mask_q       <= '0;
      bflag_q      <= '0;
      acr_update_q <= 1'b0;
      if_err_q     <= 1'b0;
      overflow_q   <= 1'b0;
      cts_q        <= '0;
      n_q          <= '0;
      vic_q        <= '0;
      ch_q         <= '0;
      freq_q       <= '0;
      ecc_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      sub_q        <= sub_d;
      mask_q       <= mask_d;
      bflag_q      <= bflag_d;
      acr_update_q <= 1'b0;
      if_err_q     <= 1'b0;
      if (bus.packet_valid && !bus.ecc_ok && ecc_cnt_q != 16'hFFFF)
        ecc_cnt_q <= ecc_cnt_q + 16'd1;
      // Lost sample (full, no simultaneous pop) or packet arriving mid-unpack.
      if ((push && fifo_full && !pop) || (accept && state_q == ST_UNPACK))
        overflow_q <= 1'b1;
      if (accept_idle) begin
        case (hb0)
          PKT_ACR: begin
            cts_q        <= {bus.sub[0][11:8],  bus.sub[0][23:16], bus.sub[0][31:24]};
            n_q          <= {bus.sub[0][35:32], bus.sub[0][47:40], bus.sub[0][55:48]};
            acr_update_q <= 1'b1;
          end
          PKT_AVI_IF: begin
            if (checksum_ok) vic_q <= bus.sub[0][38:32];
            else             if_err_q <= 1'b1;
          end
          PKT_AUDIO_IF: begin
            if (checksum_ok) begin
              ch_q   <= bus.sub[0][10:8];
              freq_q <= bus.sub[0][20:18];
            end else begin
              if_err_q <= 1'b1;
            end
          end
          PKT_NULL: ;
          default: ;
        endcase
      end
    end
  end

  assign acr_update          = acr_update_q;
  assign cts                 = cts_q;
  assign n                   = n_q;
  assign video_id_code       = vic_q;
  assign audio_channel_count = ch_q;
  assign audio_sample_freq   = freq_q;
  assign infoframe_error     = if_err_q;
  assign ecc_error_count     = ecc_cnt_q;
  assign overflow            = overflow_q;
endmodule

// File: tb/tb_packet_demux.sv
module tb_packet_demux;
  import hdmi_packet_pkg::*;

  logic clk_pixel = 1'b0;
  logic reset_n   = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  packet_demux_if #(.AUDIO_BIT_WIDTH(16)) bus();

  logic        acr_update, infoframe_error, overflow;
  logic [19:0] cts, n;
  logic [6:0]  video_id_code;
  logic [2:0]  audio_channel_count, audio_sample_freq;
  logic [15:0] ecc_error_count;
`ifdef AUDIO_PARITY_CHECK_EN
  logic        parity_error;
`endif

  packet_demux #(.AUDIO_BIT_WIDTH(16), .FIFO_DEPTH(8)) dut (
    .clk_pixel           (clk_pixel),
    .reset_n             (reset_n),
    .bus                 (bus),
    .acr_update          (acr_update),
    .cts                 (cts),
    .n                   (n),
    .video_id_code       (video_id_code),
    .audio_channel_count (audio_channel_count),
    .audio_sample_freq   (audio_sample_freq),
    .infoframe_error     (infoframe_error),
    .ecc_error_count     (ecc_error_count),
`ifdef AUDIO_PARITY_CHECK_EN
    .parity_error        (parity_error),
`endif
    .overflow            (overflow)
  );

  int checks = 0;
  int errors = 0;

  localparam subpacket_t ACR_SUB = 56'h001800A0860100;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_pixel);
    #1;
  endtask

  // Drives a packet for exactly one active edge; returns 1 time unit after it.
  task automatic send_pkt(input logic [23:0] hdr, input subpacket_t s0, input subpacket_t s1,
                          input subpacket_t s2, input subpacket_t s3, input logic ecc);
    bus.packet_valid = 1'b1;
    bus.ecc_ok       = ecc;
    bus.header       = hdr;
    bus.sub          = {s3, s2, s1, s0};
    step();
    bus.packet_valid = 1'b0;
    bus.ecc_ok       = 1'b0;
  endtask

  function automatic subpacket_t aud_sub(input int i);
    logic [15:0] ii;
    ii = i[15:0];
    return {8'h00, 16'h2000 + ii, 8'h00, 16'h1000 + ii, 8'h00};
  endfunction

  function automatic logic [31:0] aud_word(input int i);
    logic [15:0] ii;
    ii = i[15:0];
    return {16'h2000 + ii, 16'h1000 + ii};
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_acr_update"}, acr_update, 0);
    check({tag, "_cts"}, cts, 0);
    check({tag, "_n"}, n, 0);
    check({tag, "_vic"}, video_id_code, 0);
    check({tag, "_ch"}, audio_channel_count, 0);
    check({tag, "_freq"}, audio_sample_freq, 0);
    check({tag, "_if_err"}, infoframe_error, 0);
    check({tag, "_ecc_cnt"}, ecc_error_count, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_valid"}, bus.audio_valid, 0);
    check({tag, "_word"}, bus.audio_sample_word, 0);
    check({tag, "_fs"}, bus.audio_frame_start, 0);
`ifdef AUDIO_PARITY_CHECK_EN
    check({tag, "_parity"}, parity_error, 0);
`endif
  endtask

  initial begin
    bus.packet_valid = 1'b0;
    bus.ecc_ok       = 1'b0;
    bus.header       = '0;
    bus.sub          = '0;
    bus.audio_ready  = 1'b0;

    #2;
    check_zero("reset");
    #20 reset_n = 1'b1;
    step();

    // ACR decode
    send_pkt(24'h000001, ACR_SUB, '0, '0, '0, 1'b1);
    check("acr_pulse_hi", acr_update, 1);
    check("acr_cts", cts, 20'h186A0);
    check("acr_n", n, 20'h01800);
    step();
    check("acr_pulse_lo", acr_update, 0);
    check("acr_cts_hold", cts, 20'h186A0);

    // Audio packet, subpackets 0 and 2 present, B flag on subpacket 0
    send_pkt(24'h010502, 56'h88ABCDEF123456, '0, 56'h88ABCDEF123456, '0, 1'b1);
    check("aud_valid_e0", bus.audio_valid, 0);
    step();
    check("aud_valid_e1", bus.audio_valid, 1);
    check("aud_word0", bus.audio_sample_word, 32'hABCD1234);
    check("aud_fs0", bus.audio_frame_start, 1);
    bus.audio_ready = 1'b1;
    step();
    check("aud_valid_e2", bus.audio_valid, 1);
    check("aud_word1", bus.audio_sample_word, 32'hABCD1234);
    check("aud_fs1", bus.audio_frame_start, 0);
    step();
    check("aud_valid_e3", bus.audio_valid, 0);
    check("aud_no_ovf", overflow, 0);
    bus.audio_ready = 1'b0;

    // InfoFrames
    send_pkt(24'h0D0282, 56'h0000100000005F, '0, '0, '0, 1'b1);
    check("avi_vic", video_id_code, 16);
    check("avi_no_err", infoframe_error, 0);
    send_pkt(24'h0D0282, 56'h0000050000006B, '0, '0, '0, 1'b1);
    check("avi_bad_err", infoframe_error, 1);
    check("avi_bad_vic_hold", video_id_code, 16);
    step();
    check("avi_err_pulse_end", infoframe_error, 0);
    send_pkt(24'h0A0184, 56'h000000000C0164, '0, '0, '0, 1'b1);
    check("aif_ch", audio_channel_count, 1);
    check("aif_freq", audio_sample_freq, 3);
    check("aif_no_err", infoframe_error, 0);

    // ECC failure on an ACR packet
    send_pkt(24'h000001, 56'h00555504321000, '0, '0, '0, 1'b0);
    check("ecc_cts_hold", cts, 20'h186A0);
    check("ecc_n_hold", n, 20'h01800);
    check("ecc_no_pulse", acr_update, 0);
    check("ecc_count", ecc_error_count, 1);

    // Three 4-sample packets into an 8-deep FIFO with no consumer
    for (int p = 0; p < 3; p++) begin
      send_pkt(24'h010F02, aud_sub(4*p), aud_sub(4*p+1), aud_sub(4*p+2), aud_sub(4*p+3), 1'b1);
      repeat (4) step();
      if (p == 1) check("fill8_no_ovf", overflow, 0);
    end
    check("fill_ovf", overflow, 1);
    bus.audio_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      check($sformatf("drain_valid%0d", j), bus.audio_valid, 1);
      check($sformatf("drain_word%0d", j), bus.audio_sample_word, aud_word(j));
      check($sformatf("drain_fs%0d", j), bus.audio_frame_start, (j % 4 == 0) ? 1 : 0);
      step();
    end
    check("drain_empty", bus.audio_valid, 0);
    bus.audio_ready = 1'b0;

    // Asynchronous reset in the middle of UNPACK
    send_pkt(24'h010F02, aud_sub(16), aud_sub(17), aud_sub(18), aud_sub(19), 1'b1);
    step();
    check("mid_unpack_valid", bus.audio_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    check_zero("async_rst");
    #3 reset_n = 1'b1;
    step();

    // Audio after reset, with an ACR arriving two cycles into UNPACK
    send_pkt(24'h010F02, aud_sub(20), aud_sub(21), aud_sub(22), aud_sub(23), 1'b1);
    step();
    send_pkt(24'h000001, ACR_SUB, '0, '0, '0, 1'b1);
    check("drop_no_acr_pulse", acr_update, 0);
    check("drop_cts", cts, 0);
    check("drop_ovf", overflow, 1);
    bus.audio_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check($sformatf("post_valid%0d", j), bus.audio_valid, 1);
      check($sformatf("post_word%0d", j), bus.audio_sample_word, aud_word(20 + j));
      check($sformatf("post_fs%0d", j), bus.audio_frame_start, (j == 0) ? 1 : 0);
      step();
    end
    check("post_empty", bus.audio_valid, 0);
    bus.audio_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/packet_demux.md
Name: packet_demux

Overview:
- Receive-side counterpart of the HDMI TX packet selector; sits after the data-island TERC4 decode and BCH check in the sink path.
- Takes one assembled packet per strobe (header + 4 subpackets) and dispatches by HB0 packet type.
- Unpacks audio samples into a small FIFO, extracts ACR N/CTS, captures AVI and Audio InfoFrame fields, and counts dropped and erroneous packets.

Parameters:
- AUDIO_BIT_WIDTH, 16, output sample width (16..24); the MSBs of each 24-bit subframe word are taken.
- FIFO_DEPTH, 8, audio sample FIFO depth in stereo samples; must be a power of 2.

Ports:
- clk_pixel  in  1  pixel clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- packet_valid  in  1  one-cycle strobe; header/sub valid this cycle.
- ecc_ok  in  1  BCH check passed for the whole packet; qualifies packet_valid.
- header  in  24  HB0=[7:0], HB1=[15:8], HB2=[23:16].
- sub  in  4x56  subpacket k, byte SBn = sub[k][8n+7:8n].
- audio_valid  out  1  FIFO non-empty.
- audio_ready  in  1  consumer pop; a pop occurs when valid && ready.
- audio_sample_word  out  2xAUDIO_BIT_WIDTH  [0]=left, [1]=right, FIFO head.
- audio_frame_start  out  1  B flag of the FIFO head sample.
- acr_update  out  1  one-cycle pulse when cts/n are updated.
- cts  out  20  last received CTS.
- n  out  20  last received N.
- video_id_code  out  7  AVI PB4[6:0].
- audio_channel_count  out  3  Audio InfoFrame PB1[2:0].
- audio_sample_freq  out  3  Audio InfoFrame PB2[4:2].
- infoframe_error  out  1  one-cycle pulse on an InfoFrame checksum failure.
- ecc_error_count  out  16  count of packets with ecc_ok low; saturates at 16'hFFFF.
- overflow  out  1  sticky; sample lost to FIFO full or a packet arriving during UNPACK. Cleared only by reset.

Behaviour:
- Reset values: all outputs 0; FIFO empty; FSM in IDLE.
- Accept condition: packet_valid && ecc_ok.
  - packet_valid && !ecc_ok: packet discarded, ecc_error_count+1 (saturating).
- Null packet (type 0x00): ignored.
- ACR packet (type 0x01), decoded from sub[0] only:
  - CTS = {SB1[3:0], SB2, SB3}.
  - N = {SB4[3:0], SB5, SB6}.
  - cts/n register on the cycle after accept; acr_update pulses that same cycle.
- Audio sample packet (type 0x02), layout 0 only:
  - HB1[4]=1: packet ignored.
  - Present mask = HB1[3:0]; B flags = HB2[3:0].
  - Subpacket k: left = SB2..SB0 (sub[k][23:0]), right = SB5..SB3 (sub[k][47:24]); samples are the top AUDIO_BIT_WIDTH bits.
  - SB6 = {P_R, C_R, U_R, V_R, P_L, C_L, U_L, V_L}, MSB to LSB.
- Audio FSM:
  - IDLE: on an accepted audio packet with a non-zero mask, latch sub, mask and B flags; go to UNPACK. A zero mask stays in IDLE.
  - UNPACK: push one present subpacket per cycle, lowest k first. Return to IDLE after the last push, so at most 4 cycles.
  - FIFO full at a push: that sample is dropped, overflow set, unpacking continues.
  - Any accepted packet during UNPACK: dropped entirely, overflow set (non-audio types included).
- FIFO:
  - First-word-fall-through; the head is visible while audio_valid is high.
  - Simultaneous push and pop when full is legal; the count is unchanged and no overflow occurs.
  - Pointers wrap modulo FIFO_DEPTH; occupancy is tracked with an extra pointer bit.
- InfoFrames (types 0x82 AVI, 0x84 Audio):
  - Checksum: 8-bit sum of HB0..HB2 plus all 28 sub bytes (SB0..SB6 of each subpacket) must equal 0.
  - Pass: fields update the cycle after accept. AVI gives video_id_code = sub[0][38:32]. Audio gives channel count = sub[0][10:8], freq = sub[0][20:18].
  - Fail: fields held, infoframe_error pulses.
- Other types: ignored.
- Outputs not being updated hold their values.

Optional Feature:
- Macro: AUDIO_PARITY_CHECK_EN.
- Defined: each channel's P bit must equal even parity over its 24 sample bits plus V, U and C.
  - Mismatch: sample pushed with that channel zeroed.
  - Adds output parity_error (1 bit), pulsing in the push cycle.
- Undefined: P bits ignored; the parity_error port is absent.

Decomposition:
- Package hdmi_packet_pkg:
  - packet type localparams (NULL=8'h00, ACR=8'h01, AUDIO_SAMPLE=8'h02, AVI_IF=8'h82, AUDIO_IF=8'h84);
  - typedef subpacket_t (logic [55:0]);
  - checksum function.
- Sub-module audio_sample_fifo: synchronous single-clock FWFT FIFO on clk_pixel/reset_n, with push/pop/full/empty.

Test Plan:
- ACR packet, sub[0] SB1..SB6 = 0x01, 0x86, 0xA0, 0x00, 0x18, 0x00 -> cts=20'h186A0, n=20'h01800, acr_update high exactly 1 cycle.
- Audio packet, HB1=0x05, HB2=0x01, left/right = 24'h123456 / 24'hABCDEF in subpackets 0 and 2, AUDIO_BIT_WIDTH=16 -> two FIFO entries {0x1234, 0xABCD}; first has audio_frame_start=1, second 0; pushed on consecutive cycles.
- audio_ready held low, 3 packets of 4 samples with FIFO_DEPTH=8 -> 8 entries stored, overflow=1. Then pop all -> head order preserved, audio_valid falls after the 8th pop.
- AVI InfoFrame with VIC=16 and a valid checksum -> video_id_code=16. Repeat with the checksum byte +1 -> infoframe_error pulse, VIC stays 16.
- packet_valid with ecc_ok=0 on an ACR packet -> cts/n unchanged, ecc_error_count=1. Second accepted packet 2 cycles into UNPACK -> dropped, overflow=1.
- reset_n asserted mid-UNPACK -> FIFO empty, all outputs 0 immediately (asynchronous); after release, the next audio packet decodes normally.
